// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data core ports and unified memory port of the arbiter
interface mem_port_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_valid;
    logic        d_err;

    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    // master: core ports plus memory; slave: the arbiter itself
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  if_rdata, if_valid, if_err, d_rdata, d_valid, d_err,
        input  mem_req, mem_addr, mem_we, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output if_rdata, if_valid, if_err, d_rdata, d_valid, d_err,
        output mem_req, mem_addr, mem_we, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one 64-bit memory port between instruction fetch and data
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_REQ  = 2'd1;
    localparam logic [1:0]  S_WAIT = 2'd2;
    localparam logic [1:0]  S_RESP = 2'd3;
    localparam logic [7:0]  STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_owner_d;
    logic        r_sel_hi;
    logic [63:0] r_addr;
    logic        r_we;
    logic [63:0] r_wdata;
    logic [7:0]  r_starve_cnt;
    logic [15:0] r_tmo_cnt;
    logic [31:0] r_if_rdata;
    logic        r_if_valid;
    logic        r_if_err;
    logic [63:0] r_d_rdata;
    logic        r_d_valid;
    logic        r_d_err;

    logic        w_any_req;
    logic        w_pick_data;
    logic        w_done;
    logic [63:0] w_word;
    logic        w_unused;

    // Fetch only beats data once data has won STARVE_MAX times in a row over a waiting fetch
    always_comb begin
        w_any_req   = bus.if_req | bus.d_req;
        w_pick_data = bus.d_req & ~(bus.if_req & (r_starve_cnt == STARVE_LIM));
        w_done      = bus.mem_rvalid | (r_tmo_cnt == TMO_LAST);
        w_word      = bus.mem_rvalid ? bus.mem_rdata : 64'd0;
    end

    assign w_unused = ^bus.if_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner_d    <= 1'b0;
            r_sel_hi     <= 1'b0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_starve_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_if_rdata   <= '0;
            r_if_valid   <= 1'b0;
            r_if_err     <= 1'b0;
            r_d_rdata    <= '0;
            r_d_valid    <= 1'b0;
            r_d_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state   <= S_REQ;
                        r_owner_d <= w_pick_data;
                        if (w_pick_data) begin
                            r_addr  <= bus.d_addr;
                            r_we    <= bus.d_we;
                            r_wdata <= bus.d_wdata;
                            if (bus.if_req && (r_starve_cnt != STARVE_LIM))
                                r_starve_cnt <= r_starve_cnt + 8'd1;
                        end else begin
                            r_addr       <= {bus.if_addr[63:3], 3'b000};
                            r_we         <= 1'b0;
                            r_wdata      <= '0;
                            r_sel_hi     <= bus.if_addr[2];
                            r_starve_cnt <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_gnt) begin
                        r_tmo_cnt <= '0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    if (w_done) begin
                        r_state <= S_RESP;
                        if (r_owner_d) begin
                            r_d_rdata <= w_word;
                            r_d_err   <= ~bus.mem_rvalid;
                            r_d_valid <= 1'b1;
                        end else begin
                            r_if_rdata <= r_sel_hi ? w_word[63:32] : w_word[31:0];
                            r_if_err   <= ~bus.mem_rvalid;
                            r_if_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_if_valid <= 1'b0;
                    r_d_valid  <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = (r_state == S_REQ);
    assign bus.mem_addr  = r_addr;
    assign bus.mem_we    = r_we;
    assign bus.mem_wdata = r_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_err    = r_if_err;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_valid   = r_d_valid;
    assign bus.d_err     = r_d_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();
    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] env_mem [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];

    int          gnt_wait_cfg = 0;
    int          rv_delay_cfg = 0;
    bit          rv_off       = 1'b0;
    bit          inject_rv    = 1'b0;
    bit          rv_pending   = 1'b0;
    int          rv_cnt       = 0;
    logic [63:0] rv_data      = '0;
    int          req_hold     = 0;
    bit          stable_bad   = 1'b0;
    logic [63:0] first_addr, first_wdata;
    logic        first_we;
    logic [63:0] obs_addr_q[$];
    logic        obs_we_q[$];
    logic [63:0] obs_wdata_q[$];
    int          obs_cyc_q[$];
    int          obs_hold_q[$];
    int          if_pulses = 0;
    int          d_pulses  = 0;

    function automatic logic [63:0] init_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // memory environment: grants after gnt_wait_cfg held cycles, replies rv_delay_cfg cycles later
    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (rv_pending) begin
                if (rv_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rv_data;
                    rv_pending     = 1'b0;
                end else begin
                    rv_cnt = rv_cnt - 1;
                end
            end
            if (inject_rv) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
                inject_rv      = 1'b0;
            end
            if (bus.mem_req === 1'b1) begin
                if (req_hold == 0) begin
                    first_addr  = bus.mem_addr;
                    first_we    = bus.mem_we;
                    first_wdata = bus.mem_wdata;
                end else if (bus.mem_addr !== first_addr || bus.mem_we !== first_we ||
                             bus.mem_wdata !== first_wdata) begin
                    stable_bad = 1'b1;
                end
                req_hold = req_hold + 1;
                if (req_hold > gnt_wait_cfg) begin
                    bus.mem_gnt = 1'b1;
                    obs_addr_q.push_back(bus.mem_addr);
                    obs_we_q.push_back(bus.mem_we);
                    obs_wdata_q.push_back(bus.mem_wdata);
                    obs_cyc_q.push_back(cyc);
                    obs_hold_q.push_back(req_hold);
                    req_hold = 0;
                    if (bus.mem_we === 1'b1) begin
                        env_mem[bus.mem_addr] = bus.mem_wdata;
                        rv_data = '0;
                    end else begin
                        rv_data = env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr]
                                                               : init_word(bus.mem_addr);
                    end
                    rv_cnt     = rv_delay_cfg;
                    rv_pending = !rv_off;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.if_valid === 1'b1) if_pulses = if_pulses + 1;
            if (bus.d_valid === 1'b1) d_pulses = d_pulses + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        gnt_wait_cfg = 0;
        rv_delay_cfg = 0;
        rv_off       = 1'b0;
        inject_rv    = 1'b0;
        tick();
        tick();
        rv_pending = 1'b0;
        req_hold   = 0;
        stable_bad = 1'b0;
        obs_addr_q.delete();
        obs_we_q.delete();
        obs_wdata_q.delete();
        obs_cyc_q.delete();
        obs_hold_q.delete();
        if_pulses = 0;
        d_pulses  = 0;
        rst       = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit got_if, output bit got_d, output int at_cyc);
        got_if = 1'b0;
        got_d  = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.if_valid === 1'b1 || bus.d_valid === 1'b1) begin
                got_if = (bus.if_valid === 1'b1);
                got_d  = (bus.d_valid === 1'b1);
                at_cyc = cyc;
                break;
            end
        end
    endtask

    function automatic logic [63:0] obs_addr(input int k);
        return (obs_addr_q.size() > k) ? obs_addr_q[k] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic obs_we(input int k);
        return (obs_we_q.size() > k) ? obs_we_q[k] : 1'bx;
    endfunction

    task automatic test_reset();
        logic [305:0] outs;
        do_reset();
        outs = {bus.if_rdata, bus.if_valid, bus.if_err, bus.d_rdata, bus.d_valid, bus.d_err,
                bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h required 0", outs);
        end
        tick();
        n_tests++;
        if (bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: mem_req=%b if_valid=%b d_valid=%b required 0", bus.mem_req, bus.if_valid, bus.d_valid);
        end
    endtask

    task automatic test_fetch_only();
        bit gi, gd;
        int at, c0;
        do_reset();
        env_mem[64'h1000] = 64'hAAAA_BBBB_CCCC_DDDD;
        ref_mem[64'h1000] = 64'hAAAA_BBBB_CCCC_DDDD;
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h1004;
        c0 = cyc;
        wait_valid(20, gi, gd, at);
        bus.if_req = 1'b0;
        n_tests++;
        if (!gi || gd) begin
            n_fail++;
            $display("FAIL fetch_owner: if_valid=%b d_valid=%b required 1/0", gi, gd);
        end
        n_tests++;
        if (at - c0 != 3) begin
            n_fail++;
            $display("FAIL fetch_latency: got %0d cycles required 3", at - c0);
        end
        n_tests++;
        if (bus.if_rdata !== 32'hAAAA_BBBB || bus.if_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_rdata: got %h err=%b required aaaabbbb err=0", bus.if_rdata, bus.if_err);
        end
        n_tests++;
        if (obs_addr(0) !== 64'h1000 || obs_we(0) !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_mem_addr: got %h we=%b required 1000 we=0", obs_addr(0), obs_we(0));
        end
        tick();
        n_tests++;
        if (bus.if_valid !== 1'b0 || bus.if_rdata !== 32'hAAAA_BBBB) begin
            n_fail++;
            $display("FAIL fetch_pulse_width: if_valid=%b rdata=%h required 0 and held aaaabbbb", bus.if_valid, bus.if_rdata);
        end
    endtask

    task automatic test_data_priority();
        bit gi, gd;
        int at;
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h2008;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 64'h2008;
        bus.d_wdata = 64'h55;
        ref_mem[64'h2008] = 64'h55;
        wait_valid(20, gi, gd, at);
        bus.d_req = 1'b0;
        n_tests++;
        if (!gd || gi || bus.d_err !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_data_first: d_valid=%b if_valid=%b d_err=%b required 1/0/0", gd, gi, bus.d_err);
        end
        n_tests++;
        if (obs_addr(0) !== 64'h2008 || obs_we(0) !== 1'b1 ||
            obs_wdata_q.size() < 1 || obs_wdata_q[0] !== 64'h55) begin
            n_fail++;
            $display("FAIL prio_store_bus: addr=%h we=%b required 2008 we=1 wdata=55", obs_addr(0), obs_we(0));
        end
        wait_valid(20, gi, gd, at);
        bus.if_req = 1'b0;
        n_tests++;
        if (!gi || gd || bus.if_rdata !== ref_read(64'h2008) >> 0 & 64'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL prio_fetch_second: if_valid=%b rdata=%h required 1 and 00000055", gi, bus.if_rdata);
        end
    endtask

    task automatic test_starvation();
        bit gi, gd;
        int at, since_fetch;
        bit exp_d;
        logic [63:0] exp_word;
        do_reset();
        since_fetch = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h3004;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 64'h3000 + 64'(8 * $urandom_range(0, 7));
        for (int g = 0; g < 10; g++) begin
            exp_d = (since_fetch < STARVE_MAX);
            exp_word = exp_d ? ref_read(bus.d_addr) : ref_read(64'h3000);
            since_fetch = exp_d ? since_fetch + 1 : 0;
            wait_valid(20, gi, gd, at);
            n_tests++;
            if (gd !== exp_d || gi !== !exp_d) begin
                n_fail++;
                $display("FAIL starve_grant_%0d: d_valid=%b if_valid=%b required d=%b", g, gd, gi, exp_d);
            end
            n_tests++;
            if (exp_d ? (bus.d_rdata !== exp_word) : (bus.if_rdata !== exp_word[63:32])) begin
                n_fail++;
                $display("FAIL starve_data_%0d: d_rdata=%h if_rdata=%h required %h", g, bus.d_rdata, bus.if_rdata, exp_word);
            end
            if (gd) bus.d_addr = 64'h3000 + 64'(8 * $urandom_range(0, 7));
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
    endtask

    task automatic test_gnt_stall();
        bit gi, gd;
        int at, c0;
        logic [63:0] a;
        do_reset();
        gnt_wait_cfg = 10;
        a = 64'h3000 + 64'(8 * $urandom_range(0, 7));
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = a;
        c0 = cyc;
        wait_valid(40, gi, gd, at);
        bus.d_req = 1'b0;
        n_tests++;
        if (obs_hold_q.size() != 1 || obs_hold_q[0] != 11 || obs_cyc_q[0] - c0 != 11 || stable_bad) begin
            n_fail++;
            $display("FAIL stall_req_held: grants=%0d stable_bad=%b required 1 grant after 11 stable cycles", obs_hold_q.size(), stable_bad);
        end
        n_tests++;
        if (!gd || bus.d_err !== 1'b0 || bus.d_rdata !== ref_read(a)) begin
            n_fail++;
            $display("FAIL stall_complete: d_valid=%b err=%b rdata=%h required 1/0/%h", gd, bus.d_err, bus.d_rdata, ref_read(a));
        end
    endtask

    task automatic test_timeout();
        bit gi, gd;
        int at;
        do_reset();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 64'h3010;
        wait_valid(20, gi, gd, at);
        n_tests++;
        if (!gd || bus.d_rdata !== ref_read(64'h3010)) begin
            n_fail++;
            $display("FAIL tmo_preload: d_valid=%b rdata=%h required %h", gd, bus.d_rdata, ref_read(64'h3010));
        end
        rv_off     = 1'b1;
        bus.d_addr = 64'h3018;
        wait_valid(30, gi, gd, at);
        bus.d_req = 1'b0;
        n_tests++;
        if (!gd || bus.d_err !== 1'b1 || bus.d_rdata !== 64'd0) begin
            n_fail++;
            $display("FAIL tmo_error: d_valid=%b err=%b rdata=%h required 1/1/0", gd, bus.d_err, bus.d_rdata);
        end
        n_tests++;
        if (obs_cyc_q.size() != 2 || at - obs_cyc_q[1] != 9) begin
            n_fail++;
            $display("FAIL tmo_timing: got %0d cycles after gnt required 9", (obs_cyc_q.size() == 2) ? at - obs_cyc_q[1] : -1);
        end
        inject_rv = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (d_pulses != 2 || if_pulses != 0 || obs_addr_q.size() != 2) begin
            n_fail++;
            $display("FAIL tmo_late_rvalid: d_pulses=%0d if_pulses=%0d grants=%0d required 2/0/2", d_pulses, if_pulses, obs_addr_q.size());
        end
    endtask

    task automatic test_reset_in_wait();
        logic [305:0] outs;
        do_reset();
        rv_delay_cfg = 3;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 64'h3020;
        tick();
        tick();
        n_tests++;
        if (obs_addr_q.size() != 1 || bus.mem_addr !== 64'h3020) begin
            n_fail++;
            $display("FAIL rstw_reach_wait: grants=%0d mem_addr=%h required 1 and 3020", obs_addr_q.size(), bus.mem_addr);
        end
        rst = 1'b1;
        tick();
        outs = {bus.if_rdata, bus.if_valid, bus.if_err, bus.d_rdata, bus.d_valid, bus.d_err,
                bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL rstw_outputs: got %0h required 0", outs);
        end
        rst       = 1'b0;
        bus.d_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_tests++;
        if (d_pulses != 0 || if_pulses != 0 || obs_addr_q.size() != 1) begin
            n_fail++;
            $display("FAIL rstw_no_pulse: d_pulses=%0d if_pulses=%0d grants=%0d required 0/0/1", d_pulses, if_pulses, obs_addr_q.size());
        end
    endtask

    // random traffic against a queue of predicted grants built from the arbitration rules
    task automatic test_random();
        bit gi, gd, if_pend, d_pend, exp_d, d_w;
        int at, since_fetch, k;
        logic [63:0] if_a, d_a, d_wd, exp_addr, exp_word;
        bit exp_we;
        do_reset();
        if_pend = 1'b0;
        d_pend = 1'b0;
        since_fetch = 0;
        k = 0;
        for (int n = 0; n < 40; n++) begin
            if (!if_pend && ($urandom_range(0, 1) == 1 || !d_pend)) begin
                if_pend = 1'b1;
                if_a = 64'h3000 + 64'(8 * $urandom_range(0, 7)) + 64'(4 * $urandom_range(0, 1));
            end
            if (!d_pend && $urandom_range(0, 1) == 1) begin
                d_pend = 1'b1;
                d_w  = $urandom_range(0, 1) == 1;
                d_a  = 64'h3000 + 64'(8 * $urandom_range(0, 7));
                d_wd = {$urandom, $urandom};
            end
            bus.if_req  = if_pend;
            bus.if_addr = if_a;
            bus.d_req   = d_pend;
            bus.d_we    = d_w;
            bus.d_addr  = d_a;
            bus.d_wdata = d_wd;
            gnt_wait_cfg = $urandom_range(0, 2);
            rv_delay_cfg = $urandom_range(0, 3);
            exp_d = d_pend && !(if_pend && since_fetch == STARVE_MAX);
            if (exp_d) begin
                if (if_pend) since_fetch++;
                exp_addr = d_a;
                exp_we   = d_w;
                if (d_w) ref_mem[d_a] = d_wd;
                exp_word = d_w ? 64'd0 : ref_read(d_a);
            end else begin
                since_fetch = 0;
                exp_addr = {if_a[63:3], 3'b000};
                exp_we   = 1'b0;
                exp_word = if_a[2] ? {32'd0, ref_read(exp_addr) >> 32} : {32'd0, ref_read(exp_addr) & 64'hFFFF_FFFF};
            end
            wait_valid(40, gi, gd, at);
            n_tests++;
            if (gd !== exp_d || gi !== !exp_d) begin
                n_fail++;
                $display("FAIL rand_owner_%0d: d_valid=%b if_valid=%b required d=%b", n, gd, gi, exp_d);
            end
            n_tests++;
            if (exp_d ? (!exp_we && bus.d_rdata !== exp_word) || bus.d_err !== 1'b0
                      : (bus.if_rdata !== exp_word[31:0]) || bus.if_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_data_%0d: d_rdata=%h if_rdata=%h required %h", n, bus.d_rdata, bus.if_rdata, exp_word);
            end
            n_tests++;
            if (obs_addr(k) !== exp_addr || obs_we(k) !== exp_we ||
                (exp_we && obs_wdata_q[k] !== d_wd)) begin
                n_fail++;
                $display("FAIL rand_bus_%0d: addr=%h we=%b required %h we=%b", n, obs_addr(k), obs_we(k), exp_addr, exp_we);
            end
            k++;
            if (exp_d) d_pend = 1'b0;
            else if_pend = 1'b0;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_data_priority();
        test_starvation();
        test_gnt_stall();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
